// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction SRAM.
// Takes a little-endian byte stream: a 32-bit word count N, then N words.
// Each word goes to SRAM at consecutive word addresses starting at 0.
// The CPU pipeline is held in reset until the last word is written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When defined, a 4-byte
// trailer must equal the mod-2^32 sum of all data words, otherwise the load
// ends in ERR.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_HDR   | collecting the 4-byte word count
// ST_DATA  | collecting the 4 bytes of the next instruction word
// ST_WRITE | one-cycle SRAM write of the assembled word
// ST_CSUM  | collecting the 4-byte checksum trailer (macro only)
// ST_DONE  | image loaded, SRAM handed to IF, CPU out of reset
// ST_ERR   | bad header or checksum, CPU held in reset
module imem_loader #(
    parameter int AW          = 14,
    parameter int DEPTH_WORDS = 16384
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_CS,
    output logic          mem_OE,
    output logic [3:0]    mem_WEB,
    output logic [AW-1:0] mem_A,
    output logic [31:0]   mem_DI,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_HDR, ST_DATA, ST_WRITE, ST_CSUM, ST_DONE, ST_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_HDR, ST_DATA, ST_WRITE, ST_DONE, ST_ERR
    } state_t;
`endif

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;
    logic [31:0] word_count;
    logic [AW:0] word_idx;
    logic [AW:0] idx_nxt;
    logic [31:0] full_word;
    logic        accept;
    logic        last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_acc;
`endif

    // The loader never reads the SRAM.
    assign mem_OE = 1'b0;

    // Ready whenever a byte-collecting state is active; forced low in reset.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (state == ST_HDR) || (state == ST_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                       || (state == ST_CSUM)
`endif
                       ;
        end
    end

    assign accept    = in_valid && in_ready;
    assign last_byte = accept && (byte_cnt == 2'd3);
    // The 4th byte is the MSB; the word is usable in the same cycle it arrives.
    assign full_word = {in_data, low_bytes};
    assign idx_nxt   = word_idx + {{AW{1'b0}}, 1'b1};

    // Loader FSM with byte assembly and registered SRAM/CPU-control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HDR;
            byte_cnt   <= 2'd0;
            low_bytes  <= 24'd0;
            word_count <= 32'd0;
            word_idx   <= '0;
            mem_CS     <= 1'b0;
            mem_WEB    <= 4'b1111;
            mem_A      <= '0;
            mem_DI     <= 32'd0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc   <= 32'd0;
`endif
        end else begin
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    low_bytes[7:0]   <= in_data;
                    2'd1:    low_bytes[15:8]  <= in_data;
                    2'd2:    low_bytes[23:16] <= in_data;
                    default: ;
                endcase
            end

            mem_CS  <= 1'b0;
            mem_WEB <= 4'b1111;

            case (state)
                ST_HDR: begin
                    if (last_byte) begin
                        word_count <= full_word;
                        word_idx   <= '0;
                        if (full_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state   <= ST_CSUM;
`else
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
`endif
                        end else if (full_word > 32'(DEPTH_WORDS)) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (last_byte) begin
                        state   <= ST_WRITE;
                        mem_CS  <= 1'b1;
                        mem_WEB <= 4'b0000;
                        mem_A   <= word_idx[AW-1:0];
                        mem_DI  <= full_word;
                    end
                end

                ST_WRITE: begin
                    word_idx <= idx_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_acc <= csum_acc + mem_DI;
`endif
                    // Index is one bit wider than the address so N==DEPTH_WORDS
                    // still reaches the terminal compare.
                    if (32'(idx_nxt) == word_count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state   <= ST_CSUM;
`else
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
`endif
                    end else begin
                        state <= ST_DATA;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (last_byte) begin
                        if (full_word == csum_acc) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                ST_DONE: ;
                ST_ERR:  ;

                default: begin
                    state <= ST_ERR;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven images, randomized
// images with random in_valid gaps, latency and mid-load reset sequences.
module tb_imem_loader;

    localparam int AW    = 14;
    localparam int DEPTH = 16384;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_CS;
    logic          mem_OE;
    logic [3:0]    mem_WEB;
    logic [AW-1:0] mem_A;
    logic [31:0]   mem_DI;
    logic          cpu_rst;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_loader #(.AW(AW), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_CS(mem_CS), .mem_OE(mem_OE),
        .mem_WEB(mem_WEB), .mem_A(mem_A), .mem_DI(mem_DI),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] shadow [0:63];
    int          wr_count = 0;
    logic [31:0] img_q [$];

    typedef struct {
        logic [31:0]      n;
        int               nw;
        logic [3:0][31:0] w;
        logic [31:0]      csum_delta;
        bit               rnd;
        bit               exp_done;
        int               exp_writes;
    } img_vec_t;

    img_vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM stand-in plus per-cycle protocol checks derived from the outputs.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            wr_count = 0;
        end else if (mem_CS) begin
            check("wr_addr", 32'(mem_A), 32'(wr_count));
            if (mem_A < 64) shadow[mem_A] = mem_DI;
            wr_count++;
        end
        check("in_ready_rule", 32'(in_ready), 32'(!rst && !done && !err && !mem_CS));
        check("web_rule", 32'(mem_WEB), mem_CS ? 32'h0 : 32'hF);
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int  budget = 0;
        bit  taken  = 0;
        while (!taken && budget < 40) begin
            @(negedge clk);
            if (rnd && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready) taken = 1;
            end
            budget++;
        end
        if (!taken) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_timeout: in_ready never seen for byte %h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_CS", 32'(mem_CS), 32'd0);
        check("rst_mem_OE", 32'(mem_OE), 32'd0);
        check("rst_mem_WEB", 32'(mem_WEB), 32'hF);
        check("rst_mem_A", 32'(mem_A), 32'd0);
        check("rst_mem_DI", mem_DI, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] sum_q();
        logic [31:0] s = 32'd0;
        foreach (img_q[i]) s = s + img_q[i];
        return s;
    endfunction

    task automatic run_image(input logic [31:0] n, input logic [31:0] trailer, input bit rnd,
                             input bit exp_done, input int exp_writes);
        do_reset();
        send_word(n, rnd);
        foreach (img_q[i]) send_word(img_q[i], rnd);
        if (CSUM_ON && n <= 32'(DEPTH)) send_word(trailer, rnd);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(!exp_done));
        check("cpu_rst", 32'(cpu_rst), 32'(!exp_done));
        check("final_in_ready", 32'(in_ready), 32'd0);
        check("write_count", 32'(wr_count), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < 64; i++) check("sram_word", shadow[i], img_q[i]);
    endtask

    task automatic set_vec(input int k, input logic [31:0] n, input int nw,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input logic [31:0] delta, input bit rnd,
                           input bit exp_done, input int exp_writes);
        tbl[k].n          = n;
        tbl[k].nw         = nw;
        tbl[k].w          = {w3, w2, w1, w0};
        tbl[k].csum_delta = delta;
        tbl[k].rnd        = rnd;
        tbl[k].exp_done   = exp_done;
        tbl[k].exp_writes = exp_writes;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, 32'd2, 2, 32'h00000013, 32'h00100093, 0, 0, 0, 0, 1, 2);
        set_vec(1, 32'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        set_vec(2, 32'd16385, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_vec(3, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_vec(4, 32'd1, 1, 32'h00000005, 0, 0, 0, 32'd1, 0, !CSUM_ON, 1);
        set_vec(5, 32'd1, 1, 32'h00000005, 0, 0, 0, 0, 0, 1, 1);
        set_vec(6, 32'd4, 4, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h00000001,
                0, 1, 1, 4);
        set_vec(7, 32'd3, 3, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 0,
                32'hFFFFFFFF, 0, !CSUM_ON, 3);

        for (int k = 0; k < 8; k++) begin
            img_q.delete();
            for (int i = 0; i < tbl[k].nw; i++) img_q.push_back(tbl[k].w[i]);
            run_image(tbl[k].n, sum_q() + tbl[k].csum_delta, tbl[k].rnd,
                      tbl[k].exp_done, tbl[k].exp_writes);
        end

        // Randomized images with 50% in_valid gaps; first trial is N=8.
        for (int t = 0; t < 6; t++) begin
            int n;
            n = (t == 0) ? 8 : int'($urandom_range(1, 20));
            img_q.delete();
            for (int i = 0; i < n; i++) img_q.push_back($urandom);
            run_image(32'(n), sum_q(), 1'b1, 1'b1, n);
        end

        // Write latency: 4th byte at edge t -> bus write in [t,t+1], ready back at t+1.
        do_reset();
        send_word(32'd1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        @(posedge clk);
        #1;
        check("lat_cs", 32'(mem_CS), 32'd1);
        check("lat_web", 32'(mem_WEB), 32'h0);
        check("lat_addr", 32'(mem_A), 32'd0);
        check("lat_data", mem_DI, 32'h44332211);
        check("lat_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("lat_cs_off", 32'(mem_CS), 32'd0);
        check("lat_web_off", 32'(mem_WEB), 32'hF);
        check("lat_hold_data", mem_DI, 32'h44332211);
        check("lat_ready_back", 32'(in_ready), 32'(CSUM_ON));
        check("lat_done", 32'(done), 32'(!CSUM_ON));
        @(negedge clk);
        in_valid = 1'b0;
        if (CSUM_ON) begin
            send_word(32'h44332211, 1'b0);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check("lat_final_done", 32'(done), 32'd1);
        check("lat_final_cpu_rst", 32'(cpu_rst), 32'd0);

        // Reset after 6 data bytes, then a fresh image loads from address 0.
        do_reset();
        send_word(32'd3, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_wrote_one", 32'(wr_count), 32'd1);
        img_q.delete();
        for (int i = 0; i < 3; i++) img_q.push_back($urandom);
        run_image(32'd3, sum_q(), 1'b0, 1'b1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
